// File: rtl/mem_link_pkg.sv
// Shared link/command definitions for the memory link responder.
// Link bit positions, the packed link view, opcodes and the command header layout.
package mem_link_pkg;

  localparam int LINK_W    = 68;
  localparam int DATA_W    = 64;
  localparam int V_BIT     = 64;
  localparam int LAST_BIT  = 65;
  localparam int READY_BIT = 66;
  localparam int RSVD_BIT  = 67;

  typedef struct packed {
    logic              rsvd;
    logic              ready_and;
    logic              last;
    logic              v;
    logic [DATA_W-1:0] data;
  } mem_link_t;

  typedef enum logic [3:0] {
    OP_READ  = 4'h0,
    OP_WRITE = 4'h1,
    OP_UNSUP = 4'hF
  } mem_op_e;

  typedef struct packed {
    logic [35:0] rsvd;
    logic [7:0]  id;
    logic [3:0]  len;
    logic [11:0] addr;
    logic [3:0]  opcode;
  } mem_hdr_t;

  // Response header: supported opcodes are echoed, anything else reports 0xF.
  function automatic logic [DATA_W-1:0] rsp_hdr(input logic [3:0] op,
                                                 input logic [3:0] len,
                                                 input logic [7:0] id);
    mem_hdr_t h;
    h = '0;
    if (op == OP_READ || op == OP_WRITE) begin
      h.opcode = op;
    end else begin
      h.opcode = OP_UNSUP;
    end
    h.len = len;
    h.id  = id;
    return h;
  endfunction

endpackage

// File: rtl/mem_link_word_ram.sv
// DEPTH x 64-bit flop storage: one write port, one asynchronous read port, synchronous clear.
module mem_link_word_ram
  import mem_link_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: clear takes priority over a write.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_link_responder.sv
// Memory link responder: accepts read/write burst commands on the fwd link and
// answers on the rev link from a small word store.
module mem_link_responder
  import mem_link_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [LINK_W-1:0] mem_fwd_link_i,
  output logic [LINK_W-1:0] mem_fwd_link_o,
  output logic [LINK_W-1:0] mem_rev_link_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_DATA = 3'd1,
    TX_HDR  = 3'd2,
    TX_DATA = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        id_q, id_d;
  logic              rdy_en_q;

  logic              fwd_v_s, fwd_last_s, rev_ready_s;
  logic              fwd_ready_s, fwd_xfer_s, rev_xfer_s, we_s;
  logic [DATA_W-1:0] fwd_data_s, rdata_s;
  logic [AW-1:0]     word_addr_s;
  mem_hdr_t          hdr_s;
  mem_link_t         rev_s;
  logic              unused_s;

  assign fwd_v_s     = mem_fwd_link_i[V_BIT];
  assign fwd_last_s  = mem_fwd_link_i[LAST_BIT];
  assign rev_ready_s = mem_fwd_link_i[READY_BIT];
  assign fwd_data_s  = mem_fwd_link_i[DATA_W-1:0];
  assign hdr_s       = mem_hdr_t'(fwd_data_s);
  assign fwd_xfer_s  = fwd_v_s & fwd_ready_s;
  assign rev_xfer_s  = rev_s.v & rev_ready_s;
  assign word_addr_s = addr_q + AW'(cnt_q);
  assign unused_s    = ^{mem_fwd_link_i[RSVD_BIT], hdr_s.rsvd, hdr_s.addr};

  mem_link_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .clr_i   (~reset_n_i),
    .we_i    (we_s),
    .waddr_i (word_addr_s),
    .wdata_i (fwd_data_s),
    .raddr_i (word_addr_s),
    .rdata_o (rdata_s)
  );

  // Next-state and link outputs; rev outputs depend on registered state only.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    we_s        = 1'b0;
    fwd_ready_s = 1'b0;
    rev_s       = '0;
    case (state_q)
      IDLE: begin
        fwd_ready_s = rdy_en_q;
        if (fwd_xfer_s) begin
          op_d   = hdr_s.opcode;
          addr_d = hdr_s.addr[AW-1:0];
          len_d  = hdr_s.len;
          id_d   = hdr_s.id;
          cnt_d  = 4'd0;
          if (hdr_s.opcode == OP_READ) begin
            state_d = TX_HDR;
          end else if (hdr_s.opcode == OP_WRITE) begin
            state_d = RX_DATA;
          end else if (fwd_last_s) begin
            state_d = TX_HDR;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RX_DATA: begin
        fwd_ready_s = 1'b1;
        if (fwd_xfer_s) begin
          we_s = 1'b1;
          if (cnt_q == len_q) begin
            state_d = TX_HDR;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      DRAIN: begin
        fwd_ready_s = 1'b1;
        if (fwd_xfer_s && fwd_last_s) begin
          state_d = TX_HDR;
        end else begin
          state_d = DRAIN;
        end
      end
      TX_HDR: begin
        rev_s.v    = 1'b1;
        rev_s.data = rsp_hdr(op_q, len_q, id_q);
        rev_s.last = (op_q != OP_READ);
        if (rev_xfer_s) begin
          state_d = (op_q == OP_READ) ? TX_DATA : IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = TX_HDR;
        end
      end
      TX_DATA: begin
        rev_s.v    = 1'b1;
        rev_s.data = rdata_s;
        rev_s.last = (cnt_q == len_q);
        if (rev_xfer_s) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = TX_DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output link assembly: only ready_and is driven on the fwd return path.
  always_comb begin
    mem_fwd_link_o            = '0;
    mem_fwd_link_o[READY_BIT] = fwd_ready_s;
    mem_rev_link_o            = rev_s;
  end

  // State registers; rdy_en_q keeps fwd ready low for the cycle after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      addr_q   <= '0;
      len_q    <= 4'd0;
      cnt_q    <= 4'd0;
      id_q     <= 8'd0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_link_responder.sv
// Self-checking bench for mem_link_responder: directed table, corner sequences,
// and randomized commands checked against a word-array reference model.
module tb_mem_link_responder;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic             wr;
    logic [11:0]      addr;
    logic [3:0]       len;
    logic [7:0]       id;
    logic [2:0][63:0] d;
    logic [63:0]      exp_hdr;
    logic [2:0][63:0] exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fwd_v, fwd_last, rev_ready;
  logic [63:0] fwd_data;
  logic [67:0] fwd_link_i, fwd_link_o, rev_link_o;
  logic        fwd_ready, rev_v, rev_last;
  logic [63:0] rev_data;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mdl [DEPTH];
  logic [63:0] wq[$];
  logic [63:0] rq[$];
  vec_t        vecs [8];

  assign fwd_link_i = {1'b0, rev_ready, fwd_last, fwd_v, fwd_data};
  assign fwd_ready  = fwd_link_o[66];
  assign rev_v      = rev_link_o[64];
  assign rev_last   = rev_link_o[65];
  assign rev_data   = rev_link_o[63:0];

  always #5 clk = ~clk;

  mem_link_responder #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .mem_fwd_link_i (fwd_link_i),
    .mem_fwd_link_o (fwd_link_o),
    .mem_rev_link_o (rev_link_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  function automatic logic [63:0] cmd(input logic [3:0] op, input logic [11:0] a,
                                      input logic [3:0] l, input logic [7:0] id);
    return {36'd0, id, l, a, op};
  endfunction

  function automatic logic [63:0] rsp(input logic [3:0] op, input logic [3:0] l,
                                      input logic [7:0] id);
    return {36'd0, id, l, 12'd0, op};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [11:0] a, input logic [3:0] l,
                              input logic [7:0] id, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] eh, input logic [63:0] e0,
                              input logic [63:0] e1, input logic [63:0] e2);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.id = id;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.exp_hdr = eh;
    v.exp_d[0] = e0; v.exp_d[1] = e1; v.exp_d[2] = e2;
    return v;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic l, input bit gaps);
    int k;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        fwd_v    = 1'b0;
        fwd_data = {$urandom, $urandom};
        fwd_last = 1'($urandom_range(0, 1));
        step();
      end
    end
    fwd_v    = 1'b1;
    fwd_data = d;
    fwd_last = l;
    for (k = 0; k < 100 && !fwd_ready; k++) step();
    if (k == 100) timeout("fwd ready");
    step();
    fwd_v    = 1'b0;
    fwd_last = 1'b0;
  endtask

  task automatic recv_beat(output logic [63:0] d, output logic l, input bit stalls);
    int k;
    if (stalls) begin
      rev_ready = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    rev_ready = 1'b1;
    for (k = 0; k < 100 && !rev_v; k++) step();
    if (k == 100) timeout("rev valid");
    d = rev_data;
    l = rev_last;
    step();
    rev_ready = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [3:0] op, input logic [11:0] a,
                         input logic [3:0] l, input logic [7:0] id, input logic [63:0] wd[$],
                         input logic [63:0] eh, input logic [63:0] er[$], input bit rnd);
    logic [63:0] d;
    logic        lst;
    logic        bl;
    send_beat(cmd(op, a, l, id), op == 4'd0, rnd);
    if (op == 4'd1) begin
      for (int n = 0; n <= int'(l); n++) begin
        bl = (n == int'(l));
        if (rnd) bl = 1'($urandom_range(0, 1));
        send_beat(wd[n], bl, rnd);
      end
    end
    chk({nm, " latency rev_v"}, 68'(rev_v), 68'd1);
    chk({nm, " fwd ready low"}, 68'(fwd_ready), 68'd0);
    recv_beat(d, lst, rnd);
    chk({nm, " hdr"}, 68'(d), 68'(eh));
    chk({nm, " hdr last"}, 68'(lst), 68'(op != 4'd0));
    if (op == 4'd0) begin
      for (int n = 0; n <= int'(l); n++) begin
        recv_beat(d, lst, rnd);
        chk({nm, " data"}, 68'(d), 68'(er[n]));
        chk({nm, " data last"}, 68'(lst), 68'(n == int'(l)));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        lst;
    int          seen;

    for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
    reset_n = 1'b0; fwd_v = 1'b0; fwd_last = 1'b0; fwd_data = 64'd0; rev_ready = 1'b0;
    step(); step();
    chk("reset fwd link", fwd_link_o, 68'd0);
    chk("reset rev link", rev_link_o, 68'd0);
    reset_n = 1'b1;
    step();
    chk("idle fwd link", fwd_link_o, {4'b0100, 64'd0});
    chk("idle rev link", rev_link_o, 68'd0);

    vecs[0] = mk(1'b1, 12'd3,    4'd1, 8'h11, 64'hA5, 64'h5A, 64'd0, 64'h0111_0001, 64'd0, 64'd0, 64'd0);
    vecs[1] = mk(1'b0, 12'd3,    4'd1, 8'h22, 64'd0, 64'd0, 64'd0, 64'h0221_0000, 64'hA5, 64'h5A, 64'd0);
    vecs[2] = mk(1'b1, 12'd15,   4'd2, 8'h33, 64'd1, 64'd2, 64'd3, 64'h0332_0001, 64'd0, 64'd0, 64'd0);
    vecs[3] = mk(1'b0, 12'd0,    4'd1, 8'h44, 64'd0, 64'd0, 64'd0, 64'h0441_0000, 64'd2, 64'd3, 64'd0);
    vecs[4] = mk(1'b0, 12'h01F,  4'd0, 8'h55, 64'd0, 64'd0, 64'd0, 64'h0550_0000, 64'd1, 64'd0, 64'd0);
    vecs[5] = mk(1'b1, 12'hFF8,  4'd0, 8'h66, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'd0, 64'h0660_0001, 64'd0, 64'd0, 64'd0);
    vecs[6] = mk(1'b0, 12'd8,    4'd0, 8'h77, 64'd0, 64'd0, 64'd0, 64'h0770_0000, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'd0);
    vecs[7] = mk(1'b0, 12'd5,    4'd0, 8'h88, 64'd0, 64'd0, 64'd0, 64'h0880_0000, 64'd0, 64'd0, 64'd0);

    for (int i = 0; i < 8; i++) begin
      wq.delete(); rq.delete();
      for (int n = 0; n <= int'(vecs[i].len); n++) begin
        wq.push_back(vecs[i].d[n]);
        rq.push_back(vecs[i].exp_d[n]);
      end
      run_cmd($sformatf("vec%0d", i), vecs[i].wr ? 4'd1 : 4'd0, vecs[i].addr, vecs[i].len,
              vecs[i].id, wq, vecs[i].exp_hdr, rq, 1'b0);
      if (vecs[i].wr) begin
        for (int n = 0; n <= int'(vecs[i].len); n++)
          mdl[(int'(vecs[i].addr) + n) % DEPTH] = vecs[i].d[n];
      end
    end

    // Backpressure during read data.
    wq.delete(); rq.delete();
    for (int n = 0; n < 4; n++) wq.push_back(64'h1111_2222_0000_0010 + 64'(n));
    run_cmd("bp write", 4'd1, 12'd4, 4'd3, 8'h90, wq, rsp(4'd1, 4'd3, 8'h90), rq, 1'b0);
    for (int n = 0; n < 4; n++) mdl[4 + n] = wq[n];
    send_beat(cmd(4'd0, 12'd4, 4'd3, 8'h99), 1'b1, 1'b0);
    recv_beat(d, lst, 1'b0);
    chk("bp hdr", 68'(d), 68'(rsp(4'd0, 4'd3, 8'h99)));
    recv_beat(d, lst, 1'b0);
    chk("bp beat0", 68'(d), 68'(mdl[4]));
    for (int c = 0; c < 5; c++) begin
      chk("bp hold v", 68'(rev_v), 68'd1);
      chk("bp hold data", 68'(rev_data), 68'(mdl[5]));
      chk("bp hold last", 68'(rev_last), 68'd0);
      step();
    end
    for (int n = 1; n < 4; n++) begin
      recv_beat(d, lst, 1'b0);
      chk("bp beat", 68'(d), 68'(mdl[4 + n]));
      chk("bp last", 68'(lst), 68'(n == 3));
    end
    chk("bp back idle", 68'(rev_v), 68'd0);

    // Unsupported opcode drained up to last=1, single 0xF response.
    send_beat(cmd(4'd7, 12'd2, 4'd0, 8'h5A), 1'b0, 1'b0);
    chk("unsup drain ready", 68'(fwd_ready), 68'd1);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("unsup no early rsp", 68'(rev_v), 68'd0);
    send_beat(64'hEEEE_EEEE_EEEE_EEEE, 1'b1, 1'b0);
    chk("unsup rsp v", 68'(rev_v), 68'd1);
    recv_beat(d, lst, 1'b0);
    chk("unsup hdr", 68'(d), 68'h05A0_000F);
    chk("unsup last", 68'(lst), 68'd1);
    chk("unsup single rsp", 68'(rev_v), 68'd0);
    chk("unsup idle ready", 68'(fwd_ready), 68'd1);

    // Randomized commands with fwd gaps, random fwd last and rev stalls.
    for (int t = 0; t < 24; t++) begin
      logic [3:0]  op;
      logic [3:0]  len;
      logic [11:0] addr;
      logic [7:0]  id;
      op   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd1;
      addr = 12'($urandom_range(0, 4095));
      len  = 4'($urandom_range(0, 15));
      id   = 8'($urandom_range(0, 255));
      wq.delete(); rq.delete();
      for (int n = 0; n <= int'(len); n++) begin
        wq.push_back({$urandom, $urandom});
        rq.push_back(mdl[(int'(addr) + n) % DEPTH]);
      end
      run_cmd($sformatf("rand%0d", t), op, addr, len, id, wq, rsp(op, len, id), rq, 1'b1);
      if (op == 4'd1) begin
        for (int n = 0; n <= int'(len); n++) mdl[(int'(addr) + n) % DEPTH] = wq[n];
      end
    end

    // Reset in the middle of a write burst.
    send_beat(cmd(4'd1, 12'd0, 4'd3, 8'hAB), 1'b0, 1'b0);
    send_beat(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    chk("midreset fwd link", fwd_link_o, 68'd0);
    chk("midreset rev link", rev_link_o, 68'd0);
    reset_n = 1'b1;
    seen = 0;
    rev_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (rev_v) seen++;
      step();
    end
    rev_ready = 1'b0;
    chk("midreset no rsp", 68'(seen), 68'd0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
    wq.delete(); rq.delete();
    rq.push_back(64'd0);
    run_cmd("post reset rd0", 4'd0, 12'd0, 4'd0, 8'h01, wq, rsp(4'd0, 4'd0, 8'h01), rq, 1'b0);
    rq.delete();
    for (int n = 0; n < 4; n++) rq.push_back(mdl[(9 + n) % DEPTH]);
    run_cmd("post reset rd9", 4'd0, 12'd9, 4'd3, 8'h02, wq, rsp(4'd0, 4'd3, 8'h02), rq, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
